// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, reused by decode and hazard logic.
package fetch_pkg;

    localparam int unsigned INSN_W     = 32;
    localparam int unsigned ADDR_W_DEF = 32;

    localparam logic [INSN_W-1:0]     FETCH_NOP_INSN = 32'h0000_0000;
    localparam logic [ADDR_W_DEF-1:0] FETCH_RESET_PC = 32'h0100_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_STALL,
        S_REFILL
    } fetch_state_t;

    typedef struct packed {
        logic [INSN_W-1:0]     insn;
        logic [ADDR_W_DEF-1:0] pc;
        logic                  valid;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid register: captures a returning fetch, holds it, releases on clear.
module fetch_skid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              capture,
    input  logic [INSN_W-1:0] insn_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              valid,
    output logic [INSN_W-1:0] insn,
    output logic [ADDR_W-1:0] pc
);

    // Clear wins over capture: a redirect must discard whatever is parked here.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            insn  <= FETCH_NOP_INSN;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            insn  <= insn_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: fetch PC, 1-cycle imem interface, IF/ID register, stall skid.
// Build option: define FETCH_DELAY_SLOT_EN to keep the branch delay slot on redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter logic [INSN_W-1:0] NOP_INSN = FETCH_NOP_INSN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [INSN_W-1:0] i_imem_rdata,
    output logic [INSN_W-1:0] o_insn_d,
    output logic [ADDR_W-1:0] o_pc_d,
    output logic              o_valid_d
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc_f, pc_n;
    logic              inflight, inflight_n;
    logic [ADDR_W-1:0] inflight_pc, inflight_pc_n;
    logic              kill, kill_n;

    logic              skid_valid;
    logic [INSN_W-1:0] skid_insn;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_capture, skid_clear;

    logic              ifid_load;
    logic [INSN_W-1:0] ifid_insn_n;
    logic [ADDR_W-1:0] ifid_pc_n;
    logic              ifid_valid_n;

    logic              take_redirect;
    logic              resp_valid;

    // Redirect is only honoured once fetch is running and hazard detection is not stalling.
    assign take_redirect = ~reset & i_redirect & ~i_stall & (state != S_BOOT);
    assign resp_valid    = inflight & ~kill;

    assign o_imem_addr = pc_f & ALIGN_MASK;
    assign o_imem_en   = ~reset & ~i_stall & ~take_redirect & (state != S_BOOT);

    fetch_skid_reg #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .clear   (skid_clear),
        .capture (skid_capture),
        .insn_in (i_imem_rdata),
        .pc_in   (inflight_pc),
        .valid   (skid_valid),
        .insn    (skid_insn),
        .pc      (skid_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_BOOT;
            pc_f        <= RESET_PC & ALIGN_MASK;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
            o_insn_d    <= NOP_INSN;
            o_pc_d      <= '0;
            o_valid_d   <= 1'b0;
        end else begin
            state       <= state_n;
            pc_f        <= pc_n;
            inflight    <= inflight_n;
            inflight_pc <= inflight_pc_n;
            kill        <= kill_n;
            if (ifid_load) begin
                o_insn_d  <= ifid_insn_n;
                o_pc_d    <= ifid_pc_n;
                o_valid_d <= ifid_valid_n;
            end
        end
    end

    // Next-state, PC advance and IF/ID load selection.
    always_comb begin
        state_n       = state;
        pc_n          = pc_f;
        inflight_n    = o_imem_en;
        inflight_pc_n = inflight_pc;
        kill_n        = 1'b0;
        skid_capture  = 1'b0;
        skid_clear    = 1'b0;
        ifid_load     = 1'b0;
        ifid_insn_n   = NOP_INSN;
        ifid_pc_n     = '0;
        ifid_valid_n  = 1'b0;

        if (o_imem_en) begin
            inflight_pc_n = pc_f;
            pc_n          = pc_f + PC_STEP;
        end

        if (take_redirect) begin
            pc_n       = i_redirect_pc & ALIGN_MASK;
            skid_clear = 1'b1;
            ifid_load  = 1'b1;
            state_n    = S_REFILL;
`ifdef FETCH_DELAY_SLOT_EN
            // The delay slot is either parked in the skid or returning right now.
            if (skid_valid) begin
                ifid_insn_n  = skid_insn;
                ifid_pc_n    = skid_pc;
                ifid_valid_n = 1'b1;
            end else if (resp_valid) begin
                ifid_insn_n  = i_imem_rdata;
                ifid_pc_n    = inflight_pc;
                ifid_valid_n = 1'b1;
            end
`else
            kill_n = 1'b1;
`endif
        end else begin
            case (state)
                S_BOOT: begin
                    ifid_load = 1'b1;
                    state_n   = S_RUN;
                end
                S_RUN, S_REFILL: begin
                    if (i_stall) begin
                        skid_capture = resp_valid;
                        state_n      = S_STALL;
                    end else begin
                        ifid_load = 1'b1;
                        state_n   = S_RUN;
                        if (resp_valid) begin
                            ifid_insn_n  = i_imem_rdata;
                            ifid_pc_n    = inflight_pc;
                            ifid_valid_n = 1'b1;
                        end
                    end
                end
                S_STALL: begin
                    if (!i_stall) begin
                        ifid_load    = 1'b1;
                        skid_clear   = 1'b1;
                        state_n      = S_RUN;
                        ifid_valid_n = skid_valid;
                        if (skid_valid) begin
                            ifid_insn_n = skid_insn;
                            ifid_pc_n   = skid_pc;
                        end
                    end
                end
                default: begin
                    state_n = S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage; memory returns addr>>2 as the instruction word.
// Expectations follow FETCH_DELAY_SLOT_EN when the bundle is built with it.
module tb_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] B = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_en;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_insn_d;
    logic [31:0] o_pc_d;
    logic        o_valid_d;

    int n_assert = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_en     (o_imem_en),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .o_insn_d      (o_insn_d),
        .o_pc_d        (o_pc_d),
        .o_valid_d     (o_valid_d)
    );

    always #5 clock = ~clock;

    // Synchronous imem, 1-cycle latency; garbage when not strobed.
    always @(posedge clock) begin
        i_imem_rdata <= o_imem_en ? (o_imem_addr >> 2) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt,
                         input logic ev, input logic [31:0] epc);
        i_stall       = st;
        i_redirect    = rd;
        i_redirect_pc = tgt;
        exp_q.push_back({ev, epc});
        #1;
    endtask

    task automatic chk_req(input logic en, input logic [31:0] addr);
        check("imem_en", 32'(o_imem_en), 32'(en));
        if (en) check("imem_addr", o_imem_addr, addr);
    endtask

    task automatic clk_chk();
        logic [32:0] e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("valid_d", 32'(o_valid_d), 32'(e[32]));
            if (e[32]) begin
                check("pc_d", o_pc_d, e[31:0]);
                check("insn_d", o_insn_d, e[31:0] >> 2);
            end else begin
                check("bubble_insn", o_insn_d, 32'h0);
            end
        end
    endtask

    task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt,
                       input logic ev, input logic [31:0] epc);
        drive(st, rd, tgt, ev, epc);
        clk_chk();
    endtask

    initial begin
        reset = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(o_valid_d), 32'd0);
        check("rst_insn", o_insn_d, 32'h0);
        check("rst_pc", o_pc_d, 32'h0);
        check("rst_en", 32'(o_imem_en), 32'd0);

        // Boot and straight-line fetch up to the jump at B+0x10.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0); chk_req(0, 0); clk_chk();
        drive(0, 0, 0, 0, 0); chk_req(1, B); clk_chk();
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, B + 32'(4 * k));

        // Redirect to B+0x100 with the jump in decode.
        drive(0, 1, B + 32'h100, DS, B + 32'h14); chk_req(0, 0); clk_chk();
        drive(0, 0, 0, 0, 0); chk_req(1, B + 32'h100); clk_chk();
        cyc(0, 0, 0, 1, B + 32'h100);
        cyc(0, 0, 0, 1, B + 32'h104);

        // Three-cycle stall: IF/ID frozen, in-flight word parked then released.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1, B + 32'h104); chk_req(0, 0); clk_chk();
        end
        drive(0, 0, 0, 1, B + 32'h108); chk_req(1, B + 32'h10C); clk_chk();
        cyc(0, 0, 0, 1, B + 32'h10C);
        cyc(0, 0, 0, 1, B + 32'h110);

        // Redirect during stall is ignored, then taken when held into the free cycle.
        drive(1, 1, B + 32'h200, 1, B + 32'h110); chk_req(0, 0); clk_chk();
        drive(0, 1, B + 32'h200, DS, B + 32'h114); chk_req(0, 0);
        check("addr_hold", o_imem_addr, B + 32'h118);
        clk_chk();
        drive(0, 0, 0, 0, 0); chk_req(1, B + 32'h200); clk_chk();
        cyc(0, 0, 0, 1, B + 32'h200);
        cyc(0, 0, 0, 1, B + 32'h204);

        // Back-to-back redirects; the last (unaligned) target wins.
        cyc(0, 1, B + 32'h300, DS, B + 32'h208);
        drive(0, 1, B + 32'h403, 0, 0); chk_req(0, 0); clk_chk();
        drive(0, 0, 0, 0, 0); chk_req(1, B + 32'h400); clk_chk();
        cyc(0, 0, 0, 1, B + 32'h400);

        // Reset while stalled with the skid full.
        cyc(1, 0, 0, 1, B + 32'h400);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0); chk_req(0, 0); clk_chk();
        check("midrst_pc", o_pc_d, 32'h0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0); chk_req(0, 0); clk_chk();
        drive(0, 0, 0, 0, 0); chk_req(1, B); clk_chk();
        cyc(0, 0, 0, 1, B);
        cyc(0, 0, 0, 1, B + 32'h4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
